// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter: owner encodings,
// grant-vector indices, data-memory FUNC3 sizes and the muxed command record.
package dmem_arbiter_pkg;

  localparam logic [0:0] OWN_CORE_PRI  = 1'b0;
  localparam logic [0:0] OWN_EXT_BURST = 1'b1;

  localparam int REQ_CORE = 0;
  localparam int REQ_EXT  = 1;
  localparam int NUM_REQ  = 2;

  // Access sizes as decoded by the data memory
  typedef enum logic [2:0] {
    F3_BYTE  = 3'b000,
    F3_HALF  = 3'b001,
    F3_WORD  = 3'b010,
    F3_BYTEU = 3'b100,
    F3_HALFU = 3'b101
  } func3_e;

  typedef struct packed {
    logic        mrd;
    logic        mwrt;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic mem_cmd_t make_cmd(input logic we, input logic [2:0] func3,
                                        input logic [31:0] addr, input logic [31:0] wdata);
    mem_cmd_t cmd;
    cmd.mrd   = !we;
    cmd.mwrt  = we;
    cmd.func3 = func3;
    cmd.addr  = addr;
    cmd.wdata = wdata;
    return cmd;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (core, ext), the arbiter and the data memory.
interface dmem_arbiter_if;

  logic        core_req;
  logic        core_we;
  logic [2:0]  core_func3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic        ext_req;
  logic        ext_we;
  logic [2:0]  ext_func3;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_lock;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  logic        mem_mrd;
  logic        mem_mwrt;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // master: requesters plus data memory; slave: the arbiter
  modport master (
    output core_req, core_we, core_func3, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_func3, ext_addr, ext_wdata, ext_lock,
    input  ext_ack, ext_rdata,
    input  mem_mrd, mem_mwrt, mem_func3, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_func3, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_func3, ext_addr, ext_wdata, ext_lock,
    output ext_ack, ext_rdata,
    output mem_mrd, mem_mwrt, mem_func3, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_arb_fsm.sv
// Ownership FSM for the data-memory arbiter: core priority with an ext
// starvation counter and a bounded, lockable ext burst mode.
module dmem_arb_fsm
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               core_req,
  input  logic               ext_req,
  input  logic               ext_lock,
  output logic [NUM_REQ-1:0] gnt
);

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
  localparam logic [7:0] MAX_BURST8  = 8'(MAX_BURST);
  localparam logic       BURST_OK    = (MAX_BURST > 1);

  logic [0:0] owner;
  logic [7:0] wait_cnt;
  logic [7:0] beat_cnt;
  logic       ext_win;
  logic       burst_end;

  // Grant decision; in a burst ext keeps the port even when it bubbles
  always_comb begin
    ext_win = ext_req && ((owner == OWN_EXT_BURST) || !core_req || (wait_cnt == STARVE_LIM8));
    burst_end = !ext_req || !ext_lock || ((beat_cnt + 8'd1) == MAX_BURST8);
    gnt = '0;
    if (reset_n) begin
      gnt[REQ_EXT]  = ext_win;
      gnt[REQ_CORE] = core_req && (owner == OWN_CORE_PRI) && !ext_win;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner    <= OWN_CORE_PRI;
      wait_cnt <= 8'd0;
      beat_cnt <= 8'd0;
    end else begin
      if (ext_req && !ext_win) begin
        if (wait_cnt != STARVE_LIM8) begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= 8'd0;
      end

      if (owner == OWN_CORE_PRI) begin
        if (ext_win && ext_lock && BURST_OK) begin
          owner    <= OWN_EXT_BURST;
          beat_cnt <= 8'd1;
        end
      end else if (burst_end) begin
        owner    <= OWN_CORE_PRI;
        beat_cnt <= 8'd0;
      end else begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage (core) and the ext port.
// Optional DMEM_ARB_STATS_EN adds saturating stall/ext-grant cycle counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]    stat_stall,
  output logic [15:0]    stat_ext
`endif
);

  logic [NUM_REQ-1:0] gnt;
  mem_cmd_t           cmd;

  dmem_arb_fsm #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .MAX_BURST    (MAX_BURST)
  ) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .core_req (bus.core_req),
    .ext_req  (bus.ext_req),
    .ext_lock (bus.ext_lock),
    .gnt      (gnt)
  );

  // Grants are already gated by reset, so an idle or reset cycle drives all zeros
  always_comb begin
    cmd = '0;
    if (gnt[REQ_EXT]) begin
      cmd = make_cmd(bus.ext_we, bus.ext_func3, bus.ext_addr, bus.ext_wdata);
    end else if (gnt[REQ_CORE]) begin
      cmd = make_cmd(bus.core_we, bus.core_func3, bus.core_addr, bus.core_wdata);
    end
  end

  assign bus.mem_mrd    = cmd.mrd;
  assign bus.mem_mwrt   = cmd.mwrt;
  assign bus.mem_func3  = cmd.func3;
  assign bus.mem_addr   = cmd.addr;
  assign bus.mem_wdata  = cmd.wdata;

  assign bus.core_stall = reset_n && bus.core_req && !gnt[REQ_CORE];
  assign bus.ext_ack    = gnt[REQ_EXT];
  assign bus.core_rdata = reset_n ? bus.mem_rdata : 32'd0;
  assign bus.ext_rdata  = reset_n ? bus.mem_rdata : 32'd0;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_stall <= 16'd0;
      stat_ext   <= 16'd0;
    end else begin
      if (bus.core_stall) begin
        stat_stall <= sat_inc16(stat_stall);
      end
      if (bus.ext_ack) begin
        stat_ext <= sat_inc16(stat_ext);
      end
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline memory-access stage (core) and an external loader/debug port (ext).
- Core has default priority. Ext is protected from starvation by a wait counter, and may lock the port for a bounded burst.
- Generates CORE_STALL into the pipeline stall network whenever the core loses arbitration.
- Sits between the EM pipeline boundary and the data memory instance.

Parameters:
- STARVE_LIMIT, 4: consecutive denied ext cycles before ext is forced a grant. Legal range 1..255.
- MAX_BURST, 8: maximum consecutive locked ext beats. Legal range 1..255.

Ports:
- CLK  in  1  clock; all state on posedge.
- RESET_N  in  1  synchronous active-low reset.
- CORE_REQ  in  1  core memory access valid (MRd|MWrt).
- CORE_WE  in  1  core write (1) / read (0).
- CORE_FUNC3  in  3  core access size/sign.
- CORE_ADDR  in  32  core byte address.
- CORE_WDATA  in  32  core store data.
- CORE_RDATA  out  32  load data to core.
- CORE_STALL  out  1  core request not granted this cycle.
- EXT_REQ  in  1  ext access valid.
- EXT_WE  in  1  ext write / read.
- EXT_FUNC3  in  3  ext access size.
- EXT_ADDR  in  32  ext byte address.
- EXT_WDATA  in  32  ext store data.
- EXT_LOCK  in  1  ext requests burst ownership.
- EXT_ACK  out  1  ext access granted this cycle.
- EXT_RDATA  out  32  load data to ext.
- MEM_MRD  out  1  to data memory.
- MEM_MWRT  out  1  to data memory.
- MEM_FUNC3  out  3  to data memory.
- MEM_ADDR  out  32  to data memory.
- MEM_WDATA  out  32  to data memory.
- MEM_RDATA  in  32  combinational read data from data memory.

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-low (RESET_N).
- State: OWNER ∈ {CORE_PRI, EXT_BURST}; WAIT_CNT (8b); BEAT_CNT (8b).
- Reset: OWNER=CORE_PRI, WAIT_CNT=0, BEAT_CNT=0. While RESET_N=0, all outputs are forced to 0 (no grant, no stall, MEM_* zero).
- Grant is combinational from the registered state plus current requests. Read data is valid the same cycle; a write commits at the following posedge (zero-cycle arbitration latency).
- In CORE_PRI:
  - ext is granted if EXT_REQ && (!CORE_REQ || WAIT_CNT==STARVE_LIMIT);
  - otherwise core is granted if CORE_REQ.
- In EXT_BURST: ext is granted if EXT_REQ; the core is never granted.
- Outputs:
  - CORE_STALL = CORE_REQ && !GNT_CORE.
  - EXT_ACK = GNT_EXT.
- MEM_* mux: follows the winner. MEM_MRD = granted && !WE; MEM_MWRT = granted && WE. With no grant, MRD/MWRT/FUNC3/ADDR/WDATA are all 0.
- CORE_RDATA and EXT_RDATA both equal MEM_RDATA; each is meaningful only when its requester is granted and reading.
- WAIT_CNT:
  - increments, saturating at STARVE_LIMIT, on EXT_REQ && !GNT_EXT;
  - clears on GNT_EXT or !EXT_REQ.
- Transition CORE_PRI -> EXT_BURST on GNT_EXT && EXT_LOCK && MAX_BURST>1; BEAT_CNT is set to 1.
- In EXT_BURST, each GNT_EXT increments BEAT_CNT. Return to CORE_PRI, with BEAT_CNT cleared, when any of the following holds at the edge:
  - !EXT_REQ (bubble ends the burst; no ext grant that cycle);
  - !EXT_LOCK (that beat is still granted as the final beat);
  - BEAT_CNT+1==MAX_BURST on a granted beat.
- Lock-out after a burst: a burst that ends by hitting MAX_BURST leaves WAIT_CNT at 0. Ext therefore cannot regain the port while the core requests, until STARVE_LIMIT denials have accrued.
- Boundary cases:
  - CORE_REQ and EXT_REQ both present, WAIT_CNT<STARVE_LIMIT: core wins.
  - EXT_LOCK without EXT_REQ is ignored.
  - Reset mid-burst: returns to CORE_PRI next cycle.
  - An in-flight ext write on the cycle RESET_N=0 is dropped (MEM_MWRT forced 0).

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - adds outputs STAT_STALL (16b) and STAT_EXT (16b);
  - STAT_STALL counts cycles with CORE_STALL=1; STAT_EXT counts EXT_ACK cycles;
  - both saturate at 0xFFFF and clear on reset.
- Undefined: the ports and counters are absent and the block behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds: OWNER encodings (OWN_CORE_PRI=1'b0, OWN_EXT_BURST=1'b1), REQ_CORE/REQ_EXT grant-vector indices, and the FUNC3 size constants already used by the data memory.
- One natural sub-module, dmem_arb_fsm: owner state, WAIT_CNT and BEAT_CNT, producing GNT_CORE/GNT_EXT.
- The top level holds the MEM_* datapath mux and the optional stats counters.

Test Plan:
- Core only: CORE_REQ=1, WE=0, ADDR=0x100, MEM_RDATA=0xDEADBEEF -> MEM_MRD=1, MEM_ADDR=0x100, CORE_RDATA=0xDEADBEEF, CORE_STALL=0, EXT_ACK=0.
- Contention starvation: CORE_REQ and EXT_REQ held high, STARVE_LIMIT=4 -> core granted cycles 0-3; ext granted cycle 4 with CORE_STALL=1; WAIT_CNT returns to 0; core granted cycle 5.
- Burst limit: EXT_REQ=EXT_LOCK=1, CORE_REQ=1, MAX_BURST=8, WAIT_CNT forced to limit -> 8 consecutive EXT_ACK with CORE_STALL=1 throughout; cycle 9 core granted.
- Burst release: lock burst of 3 beats, then EXT_LOCK=0 on beat 4 -> beat 4 granted; next cycle OWNER=CORE_PRI and a pending core request is granted.
- Reset mid-burst: RESET_N=0 during beat 2 of an ext write burst -> MEM_MWRT=0 that cycle; after release OWNER=CORE_PRI and all outputs are 0 with no requests.
- Stats (DMEM_ARB_STATS_EN): 70000 stall cycles -> STAT_STALL=0xFFFF (saturated); reset -> 0.
